bitty_control_unit: RTL
=======================

# bitty_control_unit

Multi-cycle sequencer for the BittyPro 16-bit datapath. It accepts one instruction at a time over a valid/ready handshake and decodes it. It then steps the shared datapath (S register, C register, R0–R7 register file, operand mux, combinational ALU) through load, execute and writeback. It also keeps the carry and compare flags that the ALU produces.

## Interface
Parameters:
- INSTR_W, 16, instruction width; field layout below assumes 16
- NUM_REGS, 8, register-file entries; one-hot write-enable width

Ports:
- clk  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- instr_valid  in  1  instruction offered
- instr  in  INSTR_W  instruction word
- instr_ready  out  1  high only in IDLE
- mux_sel  out  4  operand mux: 0–7 = R0–R7, 8 = C register
- en_s  out  1  S register load (S drives ALU in_a)
- en_c  out  1  C register load (captures alu_out)
- en_reg  out  NUM_REGS  one-hot register-file write enable
- alu_sel  out  4  ALU function select
- alu_mode  out  1  ALU mode: 1 = logic, 0 = arithmetic
- alu_carry_in  out  1  ALU carry input
- alu_carry_out  in  1  ALU carry output
- alu_compare  in  1  ALU equality output (in_a == in_b)
- carry_flag  out  1  registered carry
- compare_flag  out  1  registered compare result
- done  out  1  one-cycle pulse on instruction completion
- err  out  1  one-cycle pulse on illegal format

## Operation
Instruction fields:
- [15:13] rx: destination and operand A
- [12:10] ry: operand B
- [9:5] {mode, sel}
- [4] use_carry
- [3:2] reserved, ignored
- [1:0] fmt: 00 = ALU op, 01 = compare, 10/11 = illegal

States:
- IDLE
  - instr_ready=1.
  - On instr_valid, the instruction register is loaded.
  - fmt 00/01 goes to LOAD_S; 10/11 goes to ERR.
- LOAD_S: mux_sel=rx, en_s=1. Goes to EXEC.
- EXEC
  - mux_sel=ry; alu_sel=sel; alu_mode=mode.
  - alu_carry_in = use_carry & carry_flag.
  - fmt 00: en_c=1. If mode=0, carry_flag <= alu_carry_out; if mode=1, carry_flag is unchanged and alu_carry_out is ignored. Goes to WB.
  - fmt 01: en_c=0. compare_flag <= alu_compare; done=1. Goes to IDLE.
- WB: mux_sel=8, en_reg[rx]=1, done=1. Goes to IDLE.
- ERR: err=1, no enables asserted. Goes to IDLE.

Output rules:
- alu_sel, alu_mode and alu_carry_in are driven only in EXEC and are 0 otherwise.
- mux_sel is 0 outside LOAD_S, EXEC and WB.
- At most one of en_s, en_c, en_reg is active in any cycle.
- The register file is never written for fmt 01 or ERR.

## Timing
- Handshake: a transfer happens on a cycle with instr_valid & instr_ready. instr is sampled only on that edge. instr may change freely while ready=0.
- ALU op: accepted at cycle N → LOAD_S at N+1, EXEC at N+2, WB/done at N+3, ready at N+4. Peak throughput is 1 instruction per 4 cycles.
- Compare: done at N+2, ready at N+3.
- Illegal format: err at N+1, ready at N+2.
- instr_valid held high across done: the next instruction is accepted in the first IDLE cycle, with no bubble beyond IDLE.
- Flags update on the clock edge that ends EXEC. A following instruction's EXEC sees the new value.
- Reset asserted in any state:
  - state goes to IDLE immediately (asynchronously); instruction register, carry_flag and compare_flag clear to 0.
  - All enables, done, err and ALU controls drop to 0 in the same cycle. instr_ready=1.
  - A partially executed instruction is discarded, with no register write.
- Reset values: instr_ready=1; all other outputs 0.

## Structure
- Package bitty_pkg contains:
  - state enum (IDLE, LOAD_S, EXEC, WB, ERR)
  - fmt constants (FMT_ALU=2'b00, FMT_CMP=2'b01)
  - MUX_SEL_C=4'd8
  - field bit-position constants
- One sub-module, bitty_decoder: combinational field extraction from the instruction register (rx, ry, mode, sel, use_carry, fmt, illegal). The FSM and flags stay in bitty_control_unit.

## Test plan
- **ADD R1,R2**
  - Stimulus: instr=0x2920 accepted at N; alu_carry_out=0.
  - Response: N+1 mux_sel=1, en_s=1. N+2 mux_sel=2, alu_sel=4'b1001, alu_mode=0, alu_carry_in=0, en_c=1. N+3 mux_sel=8, en_reg=8'b00000010, done=1. N+4 instr_ready=1.
- **Carry chain**
  - Stimulus: 0x2920 with alu_carry_out=1 in EXEC, then 0x2930.
  - Response: carry_flag=1 after the first EXEC; second EXEC has alu_carry_in=1.
- **Logic op preserves carry**
  - Stimulus: carry_flag=1, then instr {mode,sel}=11011 (0x2B60) with alu_carry_out=0.
  - Response: carry_flag remains 1.
- **Compare**
  - Stimulus: 0x6C01 with alu_compare=1.
  - Response: compare_flag=1 and done=1 at N+2; en_c and en_reg stay 0 throughout; ready at N+3.
- **Illegal**
  - Stimulus: instr=0x0002.
  - Response: err=1 at N+1 only; no enables asserted; ready at N+2; back-to-back valid then accepted at N+2.
- **Reset mid-op**
  - Stimulus: assert reset during EXEC of 0x2920 with carry_flag=1.
  - Response: en_c drops immediately; carry_flag=0; no en_reg pulse; instr_ready=1 after release.

Source files
------------

// File: rtl/bitty_pkg.sv
// bitty_pkg: shared definitions for the BittyPro control unit.
//   state_t    - sequencer states
//   FMT_*      - instruction format codes
//   MUX_SEL_C  - operand mux code that selects the C register
//   *_HI/_LO   - instruction field bit positions (16-bit layout)
package bitty_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_S = 3'd1,
        EXEC   = 3'd2,
        WB     = 3'd3,
        ERR    = 3'd4
    } state_t;

    localparam logic [1:0] FMT_ALU = 2'b00;
    localparam logic [1:0] FMT_CMP = 2'b01;

    localparam logic [3:0] MUX_SEL_C = 4'd8;

    localparam int RX_HI         = 15;
    localparam int RX_LO         = 13;
    localparam int RY_HI         = 12;
    localparam int RY_LO         = 10;
    localparam int MODE_BIT      = 9;
    localparam int SEL_HI        = 8;
    localparam int SEL_LO        = 5;
    localparam int USE_CARRY_BIT = 4;
    localparam int FMT_HI        = 1;
    localparam int FMT_LO        = 0;

endpackage

// File: rtl/bitty_decoder.sv
// bitty_decoder: combinational field extraction from a latched instruction.
//   instr     in  INSTR_W  instruction word
//   rx, ry    out 3        destination/operand A, operand B register indices
//   mode      out 1        ALU mode (1 = logic, 0 = arithmetic)
//   sel       out 4        ALU function select
//   use_carry out 1        chain the stored carry into the ALU
//   fmt       out 2        format code
//   illegal   out 1        format is neither ALU op nor compare
module bitty_decoder
    import bitty_pkg::*;
#(
    parameter int INSTR_W = 16
) (
    input  logic [INSTR_W-1:0] instr,
    output logic [2:0]         rx,
    output logic [2:0]         ry,
    output logic               mode,
    output logic [3:0]         sel,
    output logic               use_carry,
    output logic [1:0]         fmt,
    output logic               illegal
);

    assign rx        = instr[RX_HI:RX_LO];
    assign ry        = instr[RY_HI:RY_LO];
    assign mode      = instr[MODE_BIT];
    assign sel       = instr[SEL_HI:SEL_LO];
    assign use_carry = instr[USE_CARRY_BIT];
    assign fmt       = instr[FMT_HI:FMT_LO];
    assign illegal   = (fmt != FMT_ALU) && (fmt != FMT_CMP);

    // Bits [3:2] are reserved and deliberately ignored.
    logic unused_reserved;
    assign unused_reserved = ^instr[3:2];

endmodule

// File: rtl/bitty_control_unit.sv
// bitty_control_unit: multi-cycle sequencer for the BittyPro datapath.
//   clk, reset            clock, asynchronous active-high reset
//   instr_valid/instr     instruction offer; instr_ready high only in IDLE
//   mux_sel               operand mux (0-7 = R0-R7, 8 = C register)
//   en_s, en_c, en_reg    S load, C load, one-hot register-file write
//   alu_sel/mode/carry_in ALU controls, driven only in EXEC
//   alu_carry_out         ALU carry result, captured for arithmetic ops
//   alu_compare           ALU equality result, captured for compares
//   carry_flag            stored carry
//   compare_flag          stored compare result
//   done, err             one-cycle completion / illegal-format pulses
//
// Handshake: an instruction transfers on a rising edge where
// instr_valid && instr_ready. instr is sampled only on that edge and may
// change freely while instr_ready is low. instr_ready is high exactly
// when the sequencer is in IDLE, so a held instr_valid is accepted in the
// first IDLE cycle after completion.
module bitty_control_unit
    import bitty_pkg::*;
#(
    parameter int INSTR_W  = 16,
    parameter int NUM_REGS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                instr_valid,
    input  logic [INSTR_W-1:0]  instr,
    output logic                instr_ready,
    output logic [3:0]          mux_sel,
    output logic                en_s,
    output logic                en_c,
    output logic [NUM_REGS-1:0] en_reg,
    output logic [3:0]          alu_sel,
    output logic                alu_mode,
    output logic                alu_carry_in,
    input  logic                alu_carry_out,
    input  logic                alu_compare,
    output logic                carry_flag,
    output logic                compare_flag,
    output logic                done,
    output logic                err
);

    state_t             state_q, state_d;
    logic [INSTR_W-1:0] ir_q;

    logic [2:0] rx, ry;
    logic [3:0] sel;
    logic [1:0] fmt;
    logic       mode, use_carry, illegal;

    bitty_decoder #(.INSTR_W(INSTR_W)) u_decoder (
        .instr     (ir_q),
        .rx        (rx),
        .ry        (ry),
        .mode      (mode),
        .sel       (sel),
        .use_carry (use_carry),
        .fmt       (fmt),
        .illegal   (illegal)
    );

    // The branch out of IDLE must look at the incoming word, since the
    // instruction register is only loaded on that same edge.
    logic [1:0] fmt_in;
    assign fmt_in = instr[FMT_HI:FMT_LO];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && instr_valid) begin
                ir_q <= instr;
            end
        end
    end

    // Flags change on the edge that ends EXEC. Logic-mode ALU ops leave
    // the carry untouched so a carry chain survives interleaved logic ops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            carry_flag   <= 1'b0;
            compare_flag <= 1'b0;
        end else if (state_q == EXEC) begin
            if (fmt == FMT_ALU && !mode) begin
                carry_flag <= alu_carry_out;
            end else if (fmt == FMT_CMP) begin
                compare_flag <= alu_compare;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        instr_ready  = 1'b0;
        mux_sel      = 4'd0;
        en_s         = 1'b0;
        en_c         = 1'b0;
        en_reg       = '0;
        alu_sel      = 4'd0;
        alu_mode     = 1'b0;
        alu_carry_in = 1'b0;
        done         = 1'b0;
        err          = 1'b0;

        case (state_q)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    if (fmt_in == FMT_ALU || fmt_in == FMT_CMP) begin
                        state_d = LOAD_S;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            LOAD_S: begin
                mux_sel = {1'b0, rx};
                en_s    = 1'b1;
                state_d = EXEC;
            end
            EXEC: begin
                mux_sel      = {1'b0, ry};
                alu_sel      = sel;
                alu_mode     = mode;
                alu_carry_in = use_carry & carry_flag;
                if (fmt == FMT_ALU) begin
                    en_c    = 1'b1;
                    state_d = WB;
                end else begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            WB: begin
                mux_sel    = MUX_SEL_C;
                en_reg[rx] = 1'b1;
                done       = 1'b1;
                state_d    = IDLE;
            end
            ERR: begin
                err     = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // EXEC is only reachable from a legal format; illegal is kept for
        // observability of the decoded word and has no control effect here.
        if (illegal && state_q == EXEC) begin
            state_d = IDLE;
        end
    end

endmodule
